// File: rtl/svv_ring_fifo.sv
// svv_ring_fifo: circular status-value FIFO with push/pull/set; define SVV_FIFO_OVERWRITE_EN to overwrite oldest when full
module svv_ring_fifo #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 8,
    parameter int AFULL_THR = 6
) (
    input  logic                       clk_i,
    input  logic                       rsn_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           value_i,
    input  logic                       pull_i,
    input  logic                       set_i,
    input  logic [WIDTH-1:0]           set_value_i,
    input  logic                       clr_err_i,
    output logic [WIDTH-1:0]           value_o,
    output logic                       valid_o,
    output logic                       full_o,
    output logic                       afull_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       err_ovf_o,
    output logic                       err_udf_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH-1);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf, r_udf;
    logic             w_empty, w_full, w_set_ok, w_pull_ok, w_push_ok, w_ovw, w_ovf, w_udf;
    logic [PW-1:0]    w_newest, w_rd_nxt, w_wr_nxt;
    assign w_empty   = r_count == '0;
    assign w_full    = r_count == CW'(DEPTH);
    assign w_set_ok  = set_i && !w_empty;
    assign w_pull_ok = pull_i && !w_empty;
    assign w_push_ok = push_i && (!w_full || w_pull_ok);
    assign w_ovf     = push_i && w_full && !w_pull_ok;
    // a push into an empty FIFO absorbs the same-cycle pull without flagging underflow
    assign w_udf     = pull_i && w_empty && !push_i;
`ifdef SVV_FIFO_OVERWRITE_EN
    assign w_ovw     = w_ovf;
`else
    assign w_ovw     = 1'b0;
`endif
    assign w_newest  = r_wr_ptr == '0 ? LAST : r_wr_ptr - PW'(1);
    assign w_rd_nxt  = r_rd_ptr == LAST ? '0 : r_rd_ptr + PW'(1);
    assign w_wr_nxt  = r_wr_ptr == LAST ? '0 : r_wr_ptr + PW'(1);
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_set_ok) r_mem[w_newest] <= set_value_i;
            if (w_push_ok || w_ovw) begin
                r_mem[r_wr_ptr] <= value_i;
                r_wr_ptr        <= w_wr_nxt;
            end
            if (w_pull_ok || w_ovw) r_rd_ptr <= w_rd_nxt;
            if (w_push_ok && !w_pull_ok) r_count <= r_count + CW'(1);
            else if (w_pull_ok && !w_push_ok) r_count <= r_count - CW'(1);
            r_ovf <= w_ovf || (r_ovf && !clr_err_i);
            r_udf <= w_udf || (r_udf && !clr_err_i);
        end
    end
    assign value_o   = r_mem[r_rd_ptr];
    assign valid_o   = !w_empty;
    assign full_o    = w_full;
    assign afull_o   = r_count >= CW'(AFULL_THR);
    assign count_o   = r_count;
    assign err_ovf_o = r_ovf;
    assign err_udf_o = r_udf;
endmodule

// File: tb/tb_svv_ring_fifo.sv
// tb_svv_ring_fifo: directed self-checking bench for svv_ring_fifo at DEPTH=4, WIDTH=8, AFULL_THR=3
module tb_svv_ring_fifo;
    logic       clk_i = 1'b0, rsn_i = 1'b0;
    logic       push_i = 1'b0, pull_i = 1'b0, set_i = 1'b0, clr_err_i = 1'b0;
    logic [7:0] value_i = '0, set_value_i = '0;
    logic [7:0] value_o;
    logic       valid_o, full_o, afull_o, err_ovf_o, err_udf_o;
    logic [2:0] count_o;
    int         n_chk = 0, n_pass = 0;
    logic [7:0] exp_q [4];
    svv_ring_fifo #(.DEPTH(4), .WIDTH(8), .AFULL_THR(3)) dut (
        .clk_i(clk_i), .rsn_i(rsn_i), .push_i(push_i), .value_i(value_i), .pull_i(pull_i),
        .set_i(set_i), .set_value_i(set_value_i), .clr_err_i(clr_err_i), .value_o(value_o),
        .valid_o(valid_o), .full_o(full_o), .afull_o(afull_o), .count_o(count_o),
        .err_ovf_o(err_ovf_o), .err_udf_o(err_udf_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic cyc(input logic ps, input logic [7:0] pv, input logic pl,
                       input logic st, input logic [7:0] sv, input logic cl);
        push_i = ps; value_i = pv; pull_i = pl; set_i = st; set_value_i = sv; clr_err_i = cl;
        @(posedge clk_i);
        #1;
        push_i = 1'b0; pull_i = 1'b0; set_i = 1'b0; clr_err_i = 1'b0;
    endtask
    task automatic push(input logic [7:0] v); cyc(1'b1, v, 1'b0, 1'b0, 8'h00, 1'b0); endtask
    task automatic pull(); cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0); endtask
    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_value", value_o, 8'h00);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_full", full_o, 1'b0);
        chk("rst_afull", afull_o, 1'b0);
        chk("rst_count", count_o, 3'd0);
        chk("rst_ovf", err_ovf_o, 1'b0);
        chk("rst_udf", err_udf_o, 1'b0);
        #2 rsn_i = 1'b1;
        push(8'h11);
        chk("t1_lat_value", value_o, 8'h11);
        chk("t1_afull_lo", afull_o, 1'b0);
        push(8'h22); push(8'h33);
        chk("t1_count", count_o, 3'd3);
        chk("t1_afull", afull_o, 1'b1);
        chk("t1_value", value_o, 8'h11);
        pull();
        chk("t1_pull_value", value_o, 8'h22);
        chk("t1_pull_count", count_o, 3'd2);
        chk("t1_afull_drop", afull_o, 1'b0);
        pull(); pull();
        chk("t1_empty", valid_o, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 8'h99, 1'b0);
        chk("set_empty_count", count_o, 3'd0);
        chk("set_empty_udf", err_udf_o, 1'b0);
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        chk("t2_full", full_o, 1'b1);
        chk("t2_ovf_pre", err_ovf_o, 1'b0);
        push(8'hA4);
        chk("t2_full_after", full_o, 1'b1);
        chk("t2_count", count_o, 3'd4);
        chk("t2_ovf", err_ovf_o, 1'b1);
`ifdef SVV_FIFO_OVERWRITE_EN
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
`else
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
`endif
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("t2_clr", err_ovf_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_pop", value_o, exp_q[i]);
            pull();
        end
        chk("t2_drained", count_o, 3'd0);
        push(8'h01); push(8'h02);
        cyc(1'b1, 8'h03, 1'b0, 1'b1, 8'h7F, 1'b0);
        chk("t3_count", count_o, 3'd3);
        exp_q = '{8'h01, 8'h7F, 8'h03, 8'h00};
        for (int i = 0; i < 3; i++) begin
            chk("t3_pop", value_o, exp_q[i]);
            pull();
        end
        push(8'h55);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'h66, 1'b0);
        chk("t4_valid", valid_o, 1'b0);
        chk("t4_count", count_o, 3'd0);
        chk("t4_udf_pre", err_udf_o, 1'b0);
        pull();
        chk("t4_udf", err_udf_o, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        chk("t4_clr_vs_err", err_udf_o, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("t4_clr", err_udf_o, 1'b0);
        cyc(1'b1, 8'h44, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("empty_pushpull_count", count_o, 3'd1);
        chk("empty_pushpull_udf", err_udf_o, 1'b0);
        pull();
        for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
        cyc(1'b1, 8'hB4, 1'b1, 1'b1, 8'hCC, 1'b0);
        chk("t5_count", count_o, 3'd4);
        chk("t5_ovf", err_ovf_o, 1'b0);
        exp_q = '{8'hB1, 8'hB2, 8'hCC, 8'hB4};
        for (int i = 0; i < 4; i++) begin
            chk("t5_pop", value_o, exp_q[i]);
            pull();
        end
        pull();
        chk("t6_udf_set", err_udf_o, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'hC0 + 8'(i), i > 0, 1'b0, 8'h00, 1'b0);
        chk("t6_wrap_value", value_o, 8'hD3);
        chk("t6_wrap_count", count_o, 3'd1);
        push(8'h5A); push(8'h5B);
        chk("t6_afull", afull_o, 1'b1);
        #2 rsn_i = 1'b0;
        #1;
        chk("t6_value", value_o, 8'h00);
        chk("t6_valid", valid_o, 1'b0);
        chk("t6_afull_rst", afull_o, 1'b0);
        chk("t6_count", count_o, 3'd0);
        chk("t6_udf", err_udf_o, 1'b0);
        chk("t6_ovf", err_ovf_o, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
